// File: rtl/condlogic.sv
// Condition unit: NZCV flag register, condition evaluation, write-strobe gating and CondEx latch.
// Define COND_PERF_CNT_EN to build the executed/squashed instruction counters.
module condlogic #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  input  logic             CondExLatch,
  input  logic             CntClr,
  output logic [3:0]       Flags,
  output logic             CondEx,
  output logic             CondExReg,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [CNT_W-1:0] ExecCnt,
  output logic [CNT_W-1:0] SkipCnt
);

  logic       n, z, c, v;
  logic [1:0] flag_write;

  assign {n, z, c, v} = Flags;

  // Evaluated from the registered flags only; NV and any unlisted code resolve to 0, never x.
  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      4'h0:    CondEx = z;
      4'h1:    CondEx = ~z;
      4'h2:    CondEx = c;
      4'h3:    CondEx = ~c;
      4'h4:    CondEx = n;
      4'h5:    CondEx = ~n;
      4'h6:    CondEx = v;
      4'h7:    CondEx = ~v;
      4'h8:    CondEx = c & ~z;
      4'h9:    CondEx = ~(c & ~z);
      4'hA:    CondEx = (n == v);
      4'hB:    CondEx = (n != v);
      4'hC:    CondEx = ~z & (n == v);
      4'hD:    CondEx = ~(~z & (n == v));
      4'hE:    CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

  assign flag_write = FlagW & {2{CondEx}};
  assign PCSrc      = PCS & CondEx;
  assign RegWrite   = RegW & CondEx & ~NoWrite;
  assign MemWrite   = MemW & CondEx;

  // N,Z and C,V halves update independently so logical ops can leave C,V untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Flags <= 4'b0000;
    end else begin
      if (flag_write[1]) Flags[3:2] <= ALUFlags[3:2];
      if (flag_write[0]) Flags[1:0] <= ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      CondExReg <= 1'b0;
    end else if (CondExLatch) begin
      CondExReg <= CondEx;
    end
  end

`ifdef COND_PERF_CNT_EN
  logic [CNT_W-1:0] exec_q, skip_q;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exec_q <= '0;
      skip_q <= '0;
    end else if (CntClr) begin
      exec_q <= '0;
      skip_q <= '0;
    end else if (CondExLatch) begin
      if (CondEx) begin
        if (exec_q != CNT_MAX) exec_q <= exec_q + CNT_W'(1);
      end else begin
        if (skip_q != CNT_MAX) skip_q <= skip_q + CNT_W'(1);
      end
    end
  end

  assign ExecCnt = exec_q;
  assign SkipCnt = skip_q;
`else
  logic cntclr_unused;

  assign cntclr_unused = CntClr;
  assign ExecCnt       = '0;
  assign SkipCnt       = '0;
`endif

endmodule

// File: tb/tb_condlogic.sv
// Bench for condlogic: directed steps followed by random instructions against a flag/condition model.
module tb_condlogic;
  localparam int CNT_W = 2;

  logic             clk, reset;
  logic [3:0]       cond, aluflags;
  logic [1:0]       flagw;
  logic             pcs, regw, memw, nowrite, cexlatch, cntclr;
  logic [3:0]       flags;
  logic             condex, condexreg, pcsrc, regwrite, memwrite;
  logic [CNT_W-1:0] execcnt, skipcnt;

  int errors = 0;
  int checks = 0;

  // reference state
  logic [3:0] m_flags;
  logic       m_cr;
  int         m_exec, m_skip;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  condlogic #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Cond(cond), .ALUFlags(aluflags), .FlagW(flagw),
    .PCS(pcs), .RegW(regw), .MemW(memw), .NoWrite(nowrite), .CondExLatch(cexlatch),
    .CntClr(cntclr), .Flags(flags), .CondEx(condex), .CondExReg(condexreg),
    .PCSrc(pcsrc), .RegWrite(regwrite), .MemWrite(memwrite),
    .ExecCnt(execcnt), .SkipCnt(skipcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ARM condition table: even codes test a predicate, odd codes its inverse.
  function automatic bit cond_ok(input logic [3:0] cd, input logic [3:0] f);
    bit nn, zz, cc, vv, base;
    nn = f[3]; zz = f[2]; cc = f[1]; vv = f[0];
    if (cd == 4'hE) return 1'b1;
    if (cd == 4'hF) return 1'b0;
    case (cd[3:1])
      3'd0:    base = zz;
      3'd1:    base = cc;
      3'd2:    base = nn;
      3'd3:    base = vv;
      3'd4:    base = cc && !zz;
      3'd5:    base = (nn == vv);
      default: base = !zz && (nn == vv);
    endcase
    return cd[0] ? !base : base;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit e;
    e = cond_ok(cond, m_flags);
    chk("flags", 32'(flags), 32'(m_flags));
    chk("condex", 32'(condex), 32'(e));
    chk("condexreg", 32'(condexreg), 32'(m_cr));
    chk("pcsrc", 32'(pcsrc), 32'(pcs & e));
    chk("regwrite", 32'(regwrite), 32'(regw & e & !nowrite));
    chk("memwrite", 32'(memwrite), 32'(memw & e));
`ifdef COND_PERF_CNT_EN
    chk("execcnt", 32'(execcnt), 32'(m_exec));
    chk("skipcnt", 32'(skipcnt), 32'(m_skip));
`else
    chk("execcnt", 32'(execcnt), 32'd0);
    chk("skipcnt", 32'(skipcnt), 32'd0);
`endif
  endtask

  // Settle, check, take one clock edge, advance the model, check again.
  task automatic step();
    bit         e;
    logic [3:0] nf;
    logic       ncr;
    int         ne, ns;
    #1;
    check_all();
    e  = cond_ok(cond, m_flags);
    nf = m_flags;
    if (flagw[1] && e) nf[3:2] = aluflags[3:2];
    if (flagw[0] && e) nf[1:0] = aluflags[1:0];
    ncr = cexlatch ? e : m_cr;
    ne = m_exec; ns = m_skip;
    if (cntclr) begin
      ne = 0; ns = 0;
    end else if (cexlatch) begin
      if (e) ne = (ne < CNT_SAT) ? ne + 1 : ne;
      else   ns = (ns < CNT_SAT) ? ns + 1 : ns;
    end
    @(posedge clk);
    #1;
    m_flags = nf; m_cr = ncr; m_exec = ne; m_skip = ns;
    check_all();
  endtask

  task automatic model_reset();
    m_flags = 4'b0000; m_cr = 1'b0; m_exec = 0; m_skip = 0;
  endtask

  task automatic idle_inputs();
    cond = 4'hE; aluflags = 4'h0; flagw = 2'b00; pcs = 0; regw = 0; memw = 0;
    nowrite = 0; cexlatch = 0; cntclr = 0;
  endtask

  // Reset pulse well clear of either clock edge.
  task automatic reset_pulse();
    reset = 1'b1;
    #2;
    model_reset();
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_condexreg", 32'(condexreg), 32'h0);
    check_all();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    model_reset();
    // 1: reset state
    cond = 4'h0; regw = 1;
    #2;
    chk("t1_flags", 32'(flags), 32'h0);
    chk("t1_condex_eq", 32'(condex), 32'h0);
    chk("t1_regwrite_eq", 32'(regwrite), 32'h0);
    reset = 1'b0;
    #1;
    cond = 4'hE; #1;
    chk("t1_regwrite_al", 32'(regwrite), 32'h1);
    cond = 4'hF; #1;
    chk("t1_condex_nv", 32'(condex), 32'h0);
    @(posedge clk); #1;

    // 2: AL flag write, then EQ sees Z
    idle_inputs(); cond = 4'hE; flagw = 2'b11; aluflags = 4'b0100;
    step();
    chk("t2_flags", 32'(flags), 32'h4);
    idle_inputs(); cond = 4'h0; pcs = 1; #1;
    chk("t2_condex_eq", 32'(condex), 32'h1);
    chk("t2_pcsrc", 32'(pcsrc), 32'h1);

    // 3: squashed write, then C,V-only write
    idle_inputs(); cond = 4'h1; flagw = 2'b11; aluflags = 4'b1011;
    step();
    chk("t3_squashed", 32'(flags), 32'h4);
    idle_inputs(); cond = 4'hE; flagw = 2'b01; aluflags = 4'b1011;
    step();
    chk("t3_cv_only", 32'(flags), 32'h7);

    // 4: latch and flag write on the same edge use the old flags
    reset_pulse();
    idle_inputs(); cond = 4'hE; flagw = 2'b10; aluflags = 4'b0100; cexlatch = 1;
    step();
    chk("t4_condexreg", 32'(condexreg), 32'h1);
    chk("t4_flags", 32'(flags), 32'h4);
    idle_inputs(); cond = 4'h1; cexlatch = 1;
    step();
    chk("t4_ne_squash", 32'(condexreg), 32'h0);

    // 5: NoWrite, then reset between edges
    idle_inputs(); regw = 1; nowrite = 1; #1;
    chk("t5_nowrite", 32'(regwrite), 32'h0);
    idle_inputs(); flagw = 2'b11; aluflags = 4'hF; cexlatch = 1;
    step();
    chk("t5_flags_set", 32'(flags), 32'hF);
    reset_pulse();

    // 6: counters saturate, clear wins over increment
    idle_inputs(); cond = 4'hE; cexlatch = 1;
    for (int i = 0; i < 5; i++) step();
`ifdef COND_PERF_CNT_EN
    chk("t6_exec_sat", 32'(execcnt), 32'h3);
    chk("t6_skip", 32'(skipcnt), 32'h0);
`endif
    cntclr = 1;
    step();
    chk("t6_exec_clr", 32'(execcnt), 32'h0);
    chk("t6_skip_clr", 32'(skipcnt), 32'h0);

    // random instruction stream
    for (int i = 0; i < 300; i++) begin
      cond     = 4'($urandom_range(0, 15));
      aluflags = 4'($urandom_range(0, 15));
      flagw    = 2'($urandom_range(0, 3));
      pcs      = 1'($urandom_range(0, 1));
      regw     = 1'($urandom_range(0, 1));
      memw     = 1'($urandom_range(0, 1));
      nowrite  = 1'($urandom_range(0, 1));
      cexlatch = 1'($urandom_range(0, 1));
      cntclr   = ($urandom_range(0, 7) == 0);
      step();
      if ($urandom_range(0, 24) == 0) reset_pulse();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
